// File: rtl/cluster_priority_serializer.sv
// Frame-at-a-time priority serializer: captures a seed mask plus 3-bit counts and
// emits (strip, count) words lowest strip first, one per clock, capped at MAXCLUSTERS.
module cluster_priority_serializer #(
    parameter int NSBITS      = 64,
    parameter int MAXCLUSTERS = 8,
    parameter int ADRB        = $clog2(NSBITS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load,
    input  logic [NSBITS-1:0]   vld,
    input  logic [3*NSBITS-1:0] cnt,
    output logic                busy,
    output logic                cluster_valid,
    output logic [ADRB-1:0]     cluster_adr,
    output logic [2:0]          cluster_cnt,
    output logic                done,
    output logic                overflow,
    output logic                dropped
);

    localparam int EW = $clog2(MAXCLUSTERS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [NSBITS-1:0]   r_mask, w_mask_nxt;
    logic [3*NSBITS-1:0] r_shadow, w_shadow_nxt;
    logic [EW-1:0]       r_emit, w_emit_nxt;
    logic                r_valid, w_valid_nxt;
    logic [ADRB-1:0]     r_adr, w_adr_nxt;
    logic [2:0]          r_ccnt, w_ccnt_nxt;
    logic                r_done, w_done_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic                r_drop, w_drop_nxt;
    logic [ADRB-1:0]     w_low_idx;

    // Descending walk so the lowest set bit is the last one written.
    always_comb begin
        w_low_idx = '0;
        for (int unsigned i = NSBITS; i > 0; i--) begin
            if (r_mask[i-1]) begin
                w_low_idx = ADRB'(i - 1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_nxt   = r_mask;
        w_shadow_nxt = r_shadow;
        w_emit_nxt   = r_emit;
        w_valid_nxt  = 1'b0;
        w_adr_nxt    = r_adr;
        w_ccnt_nxt   = r_ccnt;
        w_done_nxt   = 1'b0;
        w_ovf_nxt    = r_ovf;
        w_drop_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (load) begin
                    w_mask_nxt   = vld;
                    w_shadow_nxt = cnt;
                    w_emit_nxt   = '0;
                    w_ovf_nxt    = 1'b0;
                    w_state_nxt  = S_SCAN;
                end else if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                w_drop_nxt = load;
                if ((r_mask == '0) || (r_emit == EW'(MAXCLUSTERS))) begin
                    w_done_nxt  = 1'b1;
                    w_ovf_nxt   = (r_mask != '0);
                    w_state_nxt = S_DONE;
                end else begin
                    w_adr_nxt   = w_low_idx;
                    w_ccnt_nxt  = r_shadow[3*w_low_idx +: 3];
                    w_valid_nxt = 1'b1;
                    w_mask_nxt  = r_mask & (r_mask - NSBITS'(1));
                    w_emit_nxt  = r_emit + EW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_shadow <= '0;
            r_emit   <= '0;
            r_valid  <= 1'b0;
            r_adr    <= '0;
            r_ccnt   <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_shadow <= w_shadow_nxt;
            r_emit   <= w_emit_nxt;
            r_valid  <= w_valid_nxt;
            r_adr    <= w_adr_nxt;
            r_ccnt   <= w_ccnt_nxt;
            r_done   <= w_done_nxt;
            r_ovf    <= w_ovf_nxt;
            r_drop   <= w_drop_nxt;
        end
    end

    assign busy          = (r_state == S_SCAN);
    assign cluster_valid = r_valid;
    assign cluster_adr   = r_adr;
    assign cluster_cnt   = r_ccnt;
    assign done          = r_done;
    assign overflow      = r_ovf;
    assign dropped       = r_drop;

endmodule
